// File: rtl/sv_uart_rx_packer_if.sv
// Byte-in / word-out AXI-Stream bundle for the UART receive packer.
// The packer uses the slave modport; the producer/consumer side uses master.
interface sv_uart_rx_packer_if #(
    parameter int DATA_WIDTH = 24
);
    logic [7:0]            s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/sv_uart_rx_packer.sv
// Packs WORDS_NUM received bytes MSB-first into one DATA_WIDTH AXI-Stream word.
// Optional inter-byte timeout enabled by defining SV_UART_RX_PACKER_TIMEOUT_EN.
module sv_uart_rx_packer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                          iclk,
    input  logic                          irst,
    sv_uart_rx_packer_if.slave            bus,
    input  logic                          iflush,
    input  logic [15:0]                   itimeout,
    output logic                          otimeout,
    output logic [$clog2(DATA_WIDTH/8):0] ocount
);
    localparam int WORDS_NUM = DATA_WIDTH / 8;
    localparam int CNT_W     = $clog2(WORDS_NUM) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_NUM - 1);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_t;

    out_state_t            r_out_state;
    out_state_t            w_out_state_next;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-9:0] r_acc;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_timeout;

    logic                  w_last;
    logic                  w_s_ready;
    logic                  w_byte_hs;
    logic                  w_load;
    logic                  w_tmo_expire;
    logic [DATA_WIDTH-1:0] w_shift;

    // Only the completing byte can be back-pressured; earlier bytes always fit.
    assign w_last    = (r_count == LAST_IDX);
    assign w_s_ready = !(w_last && (r_out_state == OUT_FULL) && !bus.m_axis_tready);
    assign w_byte_hs = bus.s_axis_tvalid && w_s_ready;
    assign w_shift   = {r_acc, bus.s_axis_tdata};
    assign w_load    = w_byte_hs && w_last && !iflush;

`ifdef SV_UART_RX_PACKER_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // A byte or a flush in the expiry cycle takes priority over the timeout.
    assign w_tmo_expire = (r_count != '0) && (itimeout != 16'd0) &&
                          (r_tmo_cnt >= itimeout) && !w_byte_hs && !iflush;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_byte_hs || iflush || (r_count == '0) || w_tmo_expire) begin
            r_tmo_cnt <= 16'd0;
        end else if (itimeout != 16'd0) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    logic w_unused_itimeout;

    assign w_unused_itimeout = ^itimeout;
    assign w_tmo_expire      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_expire;
            if (iflush || w_tmo_expire) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_byte_hs) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_shift[DATA_WIDTH-9:0];
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_out_state <= OUT_EMPTY;
            r_word      <= '0;
        end else begin
            r_out_state <= w_out_state_next;
            if (w_load) begin
                r_word <= w_shift;
            end
        end
    end

    // NOTE: the next state is defaulted before the case so no path can infer a latch.
    always_comb begin
        w_out_state_next = r_out_state;
        case (r_out_state)
            OUT_EMPTY: begin
                if (w_load) begin
                    w_out_state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                // A drain coinciding with a load keeps the register full (no bubble).
                if (!w_load && bus.m_axis_tready) begin
                    w_out_state_next = OUT_EMPTY;
                end
            end
            default: w_out_state_next = OUT_EMPTY;
        endcase
    end

    assign bus.s_axis_tready = w_s_ready;
    assign bus.m_axis_tvalid = (r_out_state == OUT_FULL);
    assign bus.m_axis_tdata  = r_word;
    assign otimeout          = r_timeout;
    assign ocount            = r_count;

endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// Scoreboard bench for sv_uart_rx_packer at DATA_WIDTH=24; timeout checks
// follow SV_UART_RX_PACKER_TIMEOUT_EN.
module tb_sv_uart_rx_packer;
    localparam int DW = 24;

    logic        iclk = 1'b0;
    logic        irst;
    logic        iflush;
    logic [15:0] itimeout;
    logic        otimeout;
    logic [2:0]  ocount;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    sv_uart_rx_packer_if #(.DATA_WIDTH(DW)) bus_if ();

    sv_uart_rx_packer #(.DATA_WIDTH(DW)) dut (
        .iclk     (iclk),
        .irst     (irst),
        .bus      (bus_if.slave),
        .iflush   (iflush),
        .itimeout (itimeout),
        .otimeout (otimeout),
        .ocount   (ocount)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected word.
    always @(negedge iclk) begin
        if (!irst && bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus_if.m_axis_tdata), 32'hDEAD_BEEF);
            end else begin
                check("word", 32'(bus_if.m_axis_tdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic flush);
        int n = 0;
        bus_if.s_axis_tvalid = 1'b1;
        bus_if.s_axis_tdata  = b;
        iflush               = flush;
        @(negedge iclk);
        while (!bus_if.s_axis_tready && n < 50) begin
            @(negedge iclk);
            n++;
        end
        if (n >= 50) check("byte_accept", 32'(bus_if.s_axis_tready), 32'd1);
        @(posedge iclk);
        #1;
        bus_if.s_axis_tvalid = 1'b0;
        iflush               = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    initial begin
        int   n;
        logic seen;
        irst                 = 1'b1;
        iflush               = 1'b0;
        itimeout             = 16'd0;
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tdata  = 8'h00;
        bus_if.m_axis_tready = 1'b1;
        tick(3);
        check("rst_tvalid", 32'(bus_if.m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(bus_if.m_axis_tdata), 32'd0);
        check("rst_ocount", 32'(ocount), 32'd0);
        check("rst_otimeout", 32'(otimeout), 32'd0);
        irst = 1'b0;
        tick(1);
        check("tready_after_rst", 32'(bus_if.s_axis_tready), 32'd1);

        // Basic word, tready=1
        exp_q.push_back(24'hA1B2C3);
        send_byte(8'hA1, 1'b0);
        check("ocount_1", 32'(ocount), 32'd1);
        check("tvalid_before_last", 32'(bus_if.m_axis_tvalid), 32'd0);
        send_byte(8'hB2, 1'b0);
        check("ocount_2", 32'(ocount), 32'd2);
        send_byte(8'hC3, 1'b0);
        check("ocount_0", 32'(ocount), 32'd0);
        check("tvalid_after_last", 32'(bus_if.m_axis_tvalid), 32'd1);
        tick(1);
        check("tvalid_one_cycle", 32'(bus_if.m_axis_tvalid), 32'd0);

        // Backpressure, then drain and refill in one cycle
        bus_if.m_axis_tready = 1'b0;
        exp_q.push_back(24'h112233);
        exp_q.push_back(24'h445566);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        check("bp_ocount", 32'(ocount), 32'd2);
        bus_if.s_axis_tvalid = 1'b1;
        bus_if.s_axis_tdata  = 8'h66;
        repeat (3) begin
            @(negedge iclk);
            check("bp_tready_low", 32'(bus_if.s_axis_tready), 32'd0);
            check("bp_hold_data", 32'(bus_if.m_axis_tdata), 32'h112233);
            check("bp_hold_valid", 32'(bus_if.m_axis_tvalid), 32'd1);
        end
        @(posedge iclk);
        #1;
        bus_if.m_axis_tready = 1'b1;
        @(negedge iclk);
        check("bp_tready_release", 32'(bus_if.s_axis_tready), 32'd1);
        @(posedge iclk);
        #1;
        bus_if.s_axis_tvalid = 1'b0;
        check("refill_tvalid", 32'(bus_if.m_axis_tvalid), 32'd1);
        check("refill_tdata", 32'(bus_if.m_axis_tdata), 32'h445566);
        check("refill_ocount", 32'(ocount), 32'd0);
        tick(2);
        check("refill_drained", 32'(bus_if.m_axis_tvalid), 32'd0);

        // Flush: standalone pulse, then coincident with a byte
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        iflush = 1'b1;
        tick(1);
        iflush = 1'b0;
        check("flush_ocount", 32'(ocount), 32'd0);
        exp_q.push_back(24'h0A0B0C);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'h0C, 1'b0);
        tick(2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        check("flush_coincident_ocount", 32'(ocount), 32'd0);
        exp_q.push_back(24'h0D0E0F);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0E, 1'b0);
        send_byte(8'h0F, 1'b0);
        tick(2);

        // Reset with a pending word and a partial word
        bus_if.m_axis_tready = 1'b0;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h25, 1'b0);
        check("pre_rst_ocount", 32'(ocount), 32'd2);
        check("pre_rst_tvalid", 32'(bus_if.m_axis_tvalid), 32'd1);
        irst = 1'b1;
        tick(1);
        irst = 1'b0;
        check("mid_rst_tvalid", 32'(bus_if.m_axis_tvalid), 32'd0);
        check("mid_rst_ocount", 32'(ocount), 32'd0);
        bus_if.m_axis_tready = 1'b1;
        exp_q.push_back(24'h313233);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        tick(2);

        // Timeout behaviour
        itimeout = 16'd100;
`ifdef SV_UART_RX_PACKER_TIMEOUT_EN
        send_byte(8'h55, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge iclk);
            n++;
            if (otimeout) seen = 1'b1;
        end
        check("tmo_pulse", 32'(seen), 32'd1);
        check("tmo_not_early", 32'(n >= 100), 32'd1);
        check("tmo_ocount", 32'(ocount), 32'd0);
        @(negedge iclk);
        check("tmo_one_cycle", 32'(otimeout), 32'd0);
        tick(1);

        send_byte(8'h55, 1'b0);
        tick(98);
        send_byte(8'h66, 1'b0);
        check("tmo_saved_ocount", 32'(ocount), 32'd2);
        seen = 1'b0;
        repeat (50) begin
            @(negedge iclk);
            if (otimeout) seen = 1'b1;
        end
        check("tmo_saved_no_pulse", 32'(seen), 32'd0);
        check("tmo_saved_hold", 32'(ocount), 32'd2);
        iflush = 1'b1;
        tick(1);
        iflush = 1'b0;

        itimeout = 16'd0;
        send_byte(8'h77, 1'b0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge iclk);
            if (otimeout) seen = 1'b1;
        end
        check("tmo_disabled_no_pulse", 32'(seen), 32'd0);
        check("tmo_disabled_hold", 32'(ocount), 32'd1);
`else
        send_byte(8'h55, 1'b0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge iclk);
            if (otimeout) seen = 1'b1;
        end
        check("no_tmo_quiet", 32'(seen), 32'd0);
        check("no_tmo_hold", 32'(ocount), 32'd1);
`endif
        @(posedge iclk);
        #1;
        iflush = 1'b1;
        tick(1);
        iflush = 1'b0;
        check("final_flush_ocount", 32'(ocount), 32'd0);
        tick(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sv_uart_rx_packer.md
Name: sv_uart_rx_packer

Overview:
- Downstream stage of the UART engine receive path.
- Consumes the 8-bit byte stream produced by the UART receiver and packs WORDS_NUM consecutive bytes into one DATA_WIDTH word on an AXI-Stream master.
- Byte order is MSB-first, mirroring the engine transmit side: the first byte received lands in bits [DATA_WIDTH-1 -: 8].
- Provides a flush input to drop a partial word, plus an optional inter-byte timeout.

Parameters:
- DATA_WIDTH, 24, output word width; must be a multiple of 8 and at least 16.
- WORDS_NUM, DATA_WIDTH/8, derived localparam: bytes per output word.

Ports:
- iclk  input  1  clock.
- irst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  8  received byte.
- s_axis_tvalid  input  1  byte valid.
- s_axis_tready  output  1  byte accepted when valid && ready.
- m_axis_tdata  output  DATA_WIDTH  packed word.
- m_axis_tvalid  output  1  word valid.
- m_axis_tready  input  1  downstream ready.
- iflush  input  1  one-cycle pulse that discards the partial word.
- itimeout  input  16  inter-byte timeout in iclk cycles; 0 disables it (used only with the optional feature).
- otimeout  output  1  one-cycle pulse when a partial word is dropped by timeout.
- ocount  output  $clog2(WORDS_NUM)+1  bytes currently held in the accumulator.

Behaviour:
- Reset (synchronous, irst=1), all cleared:
  - m_axis_tvalid=0, m_axis_tdata=0, otimeout=0, ocount=0.
  - Accumulator=0, timeout counter=0.
  - s_axis_tready=1 from the first cycle after reset release.
- Reset mid-word drops the partial word and any pending output word; no handshake completes in the reset cycle.
- Accumulator states:
  - EMPTY: ocount=0.
  - FILL: 0<ocount<WORDS_NUM.
- Output register states: OUT_EMPTY and OUT_FULL (m_axis_tvalid=1).
- Byte accept, when ocount<WORDS_NUM-1: acc <= {acc[DATA_WIDTH-9:0], byte}; ocount++.
- Last byte accept, when ocount==WORDS_NUM-1:
  - m_axis_tdata <= {acc[DATA_WIDTH-9:0], byte}, m_axis_tvalid <= 1.
  - ocount <= 0, acc <= 0.
  - Latency: m_axis_tvalid is asserted the cycle after the last byte handshake.
- s_axis_tready = !(ocount==WORDS_NUM-1 && m_axis_tvalid && !m_axis_tready).
  - Backpressure applies only to the completing byte.
  - If the output register drains in the same cycle the last byte is accepted, the new word loads with no bubble, so m_axis_tvalid stays 1.
- Output handshake:
  - m_axis_tvalid deasserts the cycle after valid && ready unless a new word loads in that same cycle.
  - m_axis_tdata and m_axis_tvalid hold stable while valid && !ready.
- iflush:
  - Clears acc and ocount.
  - A byte handshake in the same cycle is consumed and discarded (flush wins).
  - Does not affect a word already in the output register.
- Rules on ocount and order:
  - ocount never exceeds WORDS_NUM-1 at a clock edge.
  - No byte is lost or duplicated without an explicit flush or timeout.
  - No byte reordering.

Optional Feature:
- Macro: SV_UART_RX_PACKER_TIMEOUT_EN.
- Defined:
  - 16-bit counter runs while ocount!=0 and itimeout!=0.
  - Counter clears on every byte handshake, on iflush, and when ocount==0.
  - When the counter reaches itimeout with no byte handshake in that cycle:
    - acc and ocount are cleared.
    - otimeout pulses high for exactly one cycle, the cycle after expiry.
    - The counter clears.
  - A byte handshake in the expiry cycle wins: the byte is accepted and there is no timeout.
  - iflush in the expiry cycle gives a flush with no otimeout pulse.
  - itimeout changes take effect immediately, compared against the running count with >=.
- Not defined:
  - No counter logic.
  - otimeout tied 0; itimeout ignored.
  - A partial word is held indefinitely until completed, flushed or reset.

Test Plan (DATA_WIDTH=24):
- Bytes 0xA1,0xB2,0xC3 with m_axis_tready=1 -> one word 0xA1B2C3, m_axis_tvalid high exactly one cycle, the cycle after the 0xC3 handshake; ocount sequence 1,2,0.
- Two words back-to-back with m_axis_tready=0 -> first word 0x112233 held stable; s_axis_tready drops only when 0x66 is presented with ocount=2; releasing tready gives 0x112233 then 0x445566 with no loss.
- Drain and refill in one cycle: m_axis_tready=1 in the same cycle the last byte is accepted -> m_axis_tvalid stays 1 and the data changes to the new word.
- 0x01,0x02, then iflush, then 0x0A,0x0B,0x0C -> only 0x0A0B0C emitted; iflush coincident with byte 0x02 -> 0x02 dropped.
- Timeout (macro defined, itimeout=100): 0x55, then 100 idle cycles -> otimeout one-cycle pulse and ocount=0; byte handshake at cycle 99 -> no pulse and ocount=2; itimeout=0 -> never fires. Macro undefined -> otimeout constantly 0.
- irst asserted with ocount=2 and an output word pending -> next cycle m_axis_tvalid=0, ocount=0; next three bytes form a clean word.
